// File: rtl/rename_pkg.sv
// Shared constants and types for the rename stage with branch checkpoints.
package rename_pkg;

    localparam int N_LOG_DEF  = 32;
    localparam int N_PHYS_DEF = 64;
    localparam int N_CKPT_DEF = 4;
    localparam int TAG_W_DEF  = 5;
    localparam int LW_DEF     = $clog2(N_LOG_DEF);
    localparam int PW_DEF     = $clog2(N_PHYS_DEF);

    typedef logic [PW_DEF-1:0]    phys_t;
    typedef logic [LW_DEF-1:0]    log_t;
    typedef logic [TAG_W_DEF-1:0] rob_tag_t;

    typedef struct packed {
        logic [N_LOG_DEF-1:0][PW_DEF-1:0] map;
        logic [N_PHYS_DEF-1:0]            free;
    } rename_ckpt_t;

endpackage

// File: rtl/rename_free_pick.sv
// Lowest-set-bit priority encoder used to pick the next free physical register.
// Purely combinational, zero latency; no flow control.
module rename_free_pick #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);

    // Scan downwards so the last hit, i.e. the lowest index, wins.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                index_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/rename_ckpt_map.sv
// One-instruction-per-cycle register rename with an in-order checkpoint FIFO for branches.
// Lookups and req_ready are same-cycle; state lands next edge; stalls on empty free list, full FIFO or mispredict.
module rename_ckpt_map
    import rename_pkg::*;
#(
    parameter int  N_LOG  = N_LOG_DEF,
    parameter int  N_PHYS = N_PHYS_DEF,
    parameter int  N_CKPT = N_CKPT_DEF,
    parameter int  TAG_W  = TAG_W_DEF,
    localparam int LW     = $clog2(N_LOG),
    localparam int PW     = $clog2(N_PHYS),
    localparam int CW     = $clog2(N_CKPT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LW-1:0]    req_rs,
    input  logic [LW-1:0]    req_rt,
    input  logic [LW-1:0]    req_rd,
    input  logic             req_uses_rd,
    input  logic             req_branch,
    input  logic [TAG_W-1:0] req_rob_tag,
    output logic [PW-1:0]    rs_phy,
    output logic [PW-1:0]    rt_phy,
    output logic             rs_ready,
    output logic             rt_ready,
    output logic [TAG_W-1:0] rs_tag,
    output logic [TAG_W-1:0] rt_tag,
    output logic [PW-1:0]    rd_phy,
    output logic [PW-1:0]    rd_old_phy,
    input  logic             wb_valid,
    input  logic [PW-1:0]    wb_phy,
    input  logic             cm_free_valid,
    input  logic [PW-1:0]    cm_free_phy,
    input  logic             br_valid,
    input  logic             br_mispredict,
    output logic [PW:0]      free_count,
    output logic [CW:0]      ckpt_count
);

    logic [N_LOG-1:0][PW-1:0]     map_q, map_d;
    logic [N_PHYS-1:0]            free_q, free_d;
    logic [N_PHYS-1:0]            ready_q, ready_d;
    logic [N_PHYS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [N_LOG-1:0][PW-1:0]     ckpt_map_q [N_CKPT];
    logic [N_PHYS-1:0]            ckpt_free_q [N_CKPT];
    logic [CW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW:0]                  ckpt_count_q, ckpt_count_d;
    logic [PW:0]                  free_count_q, free_count_d, pop_cnt;

    logic          do_wr, mispredict, fire, alloc_en, push, pop, restore;
    logic          pick_found;
    logic [PW-1:0] pick_idx;

    rename_free_pick #(
        .N (N_PHYS),
        .W (PW)
    ) u_free_pick (
        .vec_i   (free_q),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    assign do_wr      = req_uses_rd && (req_rd != '0);
    assign mispredict = br_valid && br_mispredict;
    assign req_ready  = !mispredict
                        && (!do_wr || free_count_q != '0)
                        && (!req_branch || ckpt_count_q < (CW+1)'(N_CKPT));
    assign fire       = req_valid && req_ready;
    assign alloc_en   = fire && do_wr && pick_found;
    assign push       = fire && req_branch;
    // Resolves against an empty FIFO are dropped rather than corrupting pointers.
    assign pop        = br_valid && !br_mispredict && (ckpt_count_q != '0);
    assign restore    = mispredict && (ckpt_count_q != '0);

    assign free_count = free_count_q;
    assign ckpt_count = ckpt_count_q;

    always_comb begin
        rs_phy     = (req_rs == '0) ? '0 : map_q[req_rs];
        rt_phy     = (req_rt == '0) ? '0 : map_q[req_rt];
        rs_ready   = (req_rs == '0) || ready_q[rs_phy] || (wb_valid && wb_phy == rs_phy);
        rt_ready   = (req_rt == '0) || ready_q[rt_phy] || (wb_valid && wb_phy == rt_phy);
        rs_tag     = tag_q[rs_phy];
        rt_tag     = tag_q[rt_phy];
        rd_phy     = alloc_en ? pick_idx : '0;
        rd_old_phy = alloc_en ? map_q[req_rd] : '0;
    end

    always_comb begin
        map_d   = map_q;
        free_d  = free_q;
        ready_d = ready_q;
        tag_d   = tag_q;
        if (wb_valid) begin
            ready_d[wb_phy] = 1'b1;
        end
        if (alloc_en) begin
            map_d[req_rd]     = pick_idx;
            free_d[pick_idx]  = 1'b0;
            ready_d[pick_idx] = 1'b0;
            tag_d[pick_idx]   = req_rob_tag;
        end
        if (cm_free_valid) begin
            free_d[cm_free_phy] = 1'b1;
        end
        // Push and restore are exclusive, so the snapshot below sees pre-restore values.
        if (restore) begin
            map_d  = ckpt_map_q[rd_ptr_q];
            free_d = free_d | ckpt_free_q[rd_ptr_q];
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < N_PHYS; i++) begin
            pop_cnt = pop_cnt + (PW+1)'(free_d[i]);
        end
        if (restore) begin
            free_count_d = pop_cnt;
        end else begin
            free_count_d = free_count_q + (PW+1)'(cm_free_valid) - (PW+1)'(alloc_en);
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ckpt_count_d = ckpt_count_q;
        if (restore) begin
            wr_ptr_d     = rd_ptr_q;
            ckpt_count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            ckpt_count_d = ckpt_count_q + (CW+1)'(push) - (CW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LOG; i++) begin
                map_q[i] <= PW'(i);
            end
            for (int i = 0; i < N_PHYS; i++) begin
                free_q[i] <= (i >= N_LOG);
            end
            ready_q      <= '1;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ckpt_count_q <= '0;
            free_count_q <= (PW+1)'(N_PHYS - N_LOG);
        end else begin
            map_q        <= map_d;
            free_q       <= free_d;
            ready_q      <= ready_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ckpt_count_q <= ckpt_count_d;
            free_count_q <= free_count_d;
        end
    end

    // Slot contents are only meaningful while counted, so they need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ckpt_map_q[wr_ptr_q]  <= map_d;
            ckpt_free_q[wr_ptr_q] <= free_d;
        end
    end

endmodule
